// File: rtl/adc_pkg.sv
// Shared constants, FSM state type and channel-selection helper for the ADC scan controller.
package adc_pkg;

  localparam int FRAME_BITS     = 16;
  localparam int ADDR_POS_ADD2  = 3;
  localparam int DATA_FIRST_POS = 5;
  localparam int CH_W           = 3;
  localparam int CH_N           = 1 << CH_W;

  typedef enum logic [1:0] {IDLE, START, SHIFT} state_t;

  // Next enabled channel strictly above cur, wrapping; returns cur when it is the only one set.
  function automatic logic [CH_W-1:0] next_ch(input logic [CH_N-1:0] mask,
                                              input logic [CH_W-1:0] cur);
    logic [CH_W-1:0] r;
    logic [CH_W-1:0] c;
    r = cur;
    for (int i = CH_N - 1; i >= 1; i--) begin
      c = cur + CH_W'(i);
      if (mask[c]) r = c;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_sclk_gen.sv
// SCLK generator: CLK_DIV-cycle half periods, idles high, one-cycle strobes marking each edge.
module adc_sclk_gen #(
  parameter int CLK_DIV = 25
) (
  input  logic int_clk,
  input  logic rst,
  input  logic en,
  output logic sclk,
  output logic fall_pulse,
  output logic rise_pulse
);

  localparam int CNT_W = $clog2(CLK_DIV);

  logic [CNT_W-1:0] cnt;
  logic             half_done;

  assign half_done = (cnt == CNT_W'(CLK_DIV - 1));

  // Strobes are registered alongside sclk so they mark the cycle in which the new level appears.
  always_ff @(posedge int_clk or posedge rst) begin
    if (rst) begin
      cnt        <= '0;
      sclk       <= 1'b1;
      fall_pulse <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      fall_pulse <= 1'b0;
      rise_pulse <= 1'b0;
      if (!en) begin
        cnt  <= '0;
        sclk <= 1'b1;
      end else if (half_done) begin
        cnt        <= '0;
        sclk       <= ~sclk;
        fall_pulse <= sclk;
        rise_pulse <= ~sclk;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/adc_scan_controller.sv
// Round-robin scan of an 8-channel serial ADC; publishes each result with its channel and threshold flag.
module adc_scan_controller
  import adc_pkg::*;
#(
  parameter int CLK_DIV = 25,
  parameter int NUM_CH  = 8,
  parameter int DATA_W  = 12
) (
  input  logic              int_clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [DATA_W-1:0] threshold,
  input  logic              dout,
  output logic              cs,
  output logic              sclk,
  output logic              din,
  output logic [DATA_W-1:0] sample_data,
  output logic [CH_W-1:0]   sample_ch,
  output logic              sample_valid,
  output logic [NUM_CH-1:0] digital_bits
);

  localparam int BC_W = $clog2(FRAME_BITS + 1);

  state_t            state, state_nxt;
  logic              fall_pulse, rise_pulse;
  logic              run_req, frame_end, capture, thr_load, din_bit;
  logic [BC_W-1:0]   bit_cnt;
  logic [CH_W-1:0]   addr, prev_ch;
  logic              first_frame;
  logic              dout_p0, dout_p1;
  logic [DATA_W-1:0] shreg, thr_q, word;

  adc_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .int_clk    (int_clk),
    .rst        (rst),
    .en         (state != IDLE),
    .sclk       (sclk),
    .fall_pulse (fall_pulse),
    .rise_pulse (rise_pulse)
  );

  assign run_req   = enable && (ch_mask != '0);
  assign frame_end = (state == SHIFT) && rise_pulse && (bit_cnt == BC_W'(FRAME_BITS));
  assign capture   = (state != IDLE) && rise_pulse && (bit_cnt >= BC_W'(DATA_FIRST_POS));
  assign thr_load  = run_req && ((state == IDLE) || frame_end);
  assign word      = {shreg[DATA_W-2:0], dout_p1};

  always_ff @(posedge int_clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    cs        = 1'b1;
    case (state)
      IDLE:  if (run_req) state_nxt = START;
      START: begin
        cs = 1'b0;
        if (fall_pulse) state_nxt = SHIFT;
      end
      SHIFT: begin
        cs = 1'b0;
        if (frame_end && !run_req) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // bit_cnt holds the number of falling edges already seen, so the upcoming edge is bit_cnt+1.
  always_comb begin
    din_bit = 1'b0;
    case (bit_cnt)
      BC_W'(ADDR_POS_ADD2 - 1): din_bit = addr[2];
      BC_W'(ADDR_POS_ADD2):     din_bit = addr[1];
      BC_W'(ADDR_POS_ADD2 + 1): din_bit = addr[0];
      default:                  din_bit = 1'b0;
    endcase
  end

  // Result read in a frame belongs to the address sent in the previous frame (prev_ch).
  always_ff @(posedge int_clk or posedge rst) begin
    if (rst) begin
      dout_p0      <= 1'b0;
      dout_p1      <= 1'b0;
      din          <= 1'b0;
      bit_cnt      <= '0;
      addr         <= '0;
      prev_ch      <= '0;
      first_frame  <= 1'b1;
      sample_valid <= 1'b0;
      sample_ch    <= '0;
      sample_data  <= '0;
      digital_bits <= '0;
    end else begin
      dout_p0      <= dout;
      dout_p1      <= dout_p0;
      sample_valid <= 1'b0;
      if (state == IDLE) begin
        bit_cnt <= '0;
        din     <= 1'b0;
        if (run_req) begin
          addr        <= next_ch(ch_mask, {CH_W{1'b1}});
          first_frame <= 1'b1;
        end
      end else begin
        if (fall_pulse) begin
          bit_cnt <= bit_cnt + 1'b1;
          din     <= din_bit;
        end
        if (frame_end) begin
          if (!first_frame) begin
            sample_valid          <= 1'b1;
            sample_data           <= word;
            sample_ch             <= prev_ch;
            digital_bits[prev_ch] <= (word > thr_q);
          end
          prev_ch     <= addr;
          first_frame <= 1'b0;
          bit_cnt     <= '0;
          if (run_req) addr <= next_ch(ch_mask, addr);
        end
      end
    end
  end

  always_ff @(posedge int_clk) begin
    if (capture)  shreg <= {shreg[DATA_W-2:0], dout_p1};
    if (thr_load) thr_q <= threshold;
  end

endmodule

// File: tb/tb_adc_scan_controller.sv
// Bench for adc_scan_controller: behavioural ADC model, sample monitor and a channel-sequence reference model.
module tb_adc_scan_controller;

  localparam int D = 4;

  logic        int_clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [7:0]  ch_mask = '0;
  logic [11:0] threshold = '0;
  logic        dout = 1'b0;
  logic        cs, sclk, din, sample_valid;
  logic [11:0] sample_data;
  logic [2:0]  sample_ch;
  logic [7:0]  digital_bits;

  adc_scan_controller #(.CLK_DIV(D), .NUM_CH(8), .DATA_W(12)) dut (
    .int_clk      (int_clk),
    .rst          (rst),
    .enable       (enable),
    .ch_mask      (ch_mask),
    .threshold    (threshold),
    .dout         (dout),
    .cs           (cs),
    .sclk         (sclk),
    .din          (din),
    .sample_data  (sample_data),
    .sample_ch    (sample_ch),
    .sample_valid (sample_valid),
    .digital_bits (digital_bits)
  );

  always #5 int_clk = ~int_clk;

  typedef struct {
    logic [2:0]  ch;
    logic [11:0] data;
    logic [7:0]  bits;
    int          cyc;
  } pub_t;

  int          checks = 0;
  int          failures = 0;
  logic [11:0] val [8];
  pub_t        pub_q[$];
  int          addr_q[$];
  pub_t        mon_p;
  int          cyc = 0, n_fall = 0, n_rise = 0;
  int          last_rise_cyc = 0, cs_fall_cyc = 0, cs_rise_cyc = 0;
  logic        sclk_d = 1'b1, cs_d = 1'b1;

  // Monitor: sampled on the falling int_clk edge, away from DUT updates.
  always @(negedge int_clk) begin
    if (sample_valid === 1'b1) begin
      mon_p.ch   = sample_ch;
      mon_p.data = sample_data;
      mon_p.bits = digital_bits;
      mon_p.cyc  = cyc;
      pub_q.push_back(mon_p);
    end
    if (sclk_d === 1'b1 && sclk === 1'b0) n_fall <= n_fall + 1;
    if (sclk_d === 1'b0 && sclk === 1'b1) begin
      n_rise        <= n_rise + 1;
      last_rise_cyc <= cyc;
    end
    if (cs_d === 1'b1 && cs === 1'b0) cs_fall_cyc <= cyc;
    if (cs_d === 1'b0 && cs === 1'b1) cs_rise_cyc <= cyc;
    sclk_d <= sclk;
    cs_d   <= cs;
    cyc    <= cyc + 1;
  end

  // ADC model: address latched on rising edges 3..5, result of the previous address shifted out on falls 5..16.
  int          fk = 0, rk = 0;
  logic [2:0]  lat_addr = '0, cur_addr = '0;
  logic [11:0] mdl_sh = '0;
  always @(posedge sclk or negedge sclk or posedge cs) begin
    if (cs === 1'b1) begin
      fk = 0; rk = 0; cur_addr = '0; dout = 1'b0;
    end else if (sclk === 1'b0) begin
      fk = (fk % 16) + 1;
      if (fk == 5) mdl_sh = val[cur_addr];
      if (fk >= 5) begin
        dout   = mdl_sh[11];
        mdl_sh = mdl_sh << 1;
      end else begin
        dout = 1'b0;
      end
    end else begin
      rk = (rk % 16) + 1;
      case (rk)
        3: lat_addr[2] = din;
        4: lat_addr[1] = din;
        5: lat_addr[0] = din;
        default: ;
      endcase
      if (rk == 16) begin
        cur_addr = lat_addr;
        addr_q.push_back(int'(lat_addr));
      end
    end
  end

  function automatic int lowest_ch(input logic [7:0] m);
    for (int c = 0; c < 8; c++) if (m[c[2:0]]) return c;
    return 0;
  endfunction

  function automatic int next_ref(input logic [7:0] m, input int cur);
    int idx;
    for (int j = 1; j <= 8; j++) begin
      idx = (cur + j) % 8;
      if (m[idx[2:0]]) return idx;
    end
    return cur;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge int_clk);
    #2;
  endtask

  int          pbase, abase, fbase, rbase;
  logic [7:0]  run_mask;
  logic [11:0] run_thr;
  logic [7:0]  exp_bits = '0;

  task automatic start_run(input logic [7:0] m, input logic [11:0] t);
    pbase     = pub_q.size();
    abase     = addr_q.size();
    fbase     = n_fall;
    rbase     = n_rise;
    run_mask  = m;
    run_thr   = t;
    ch_mask   = m;
    threshold = t;
    enable    = 1'b1;
  endtask

  task automatic wait_pubs(input int n);
    int i = 0;
    while ((pub_q.size() - pbase) < n && i < (n + 3) * 32 * D) begin
      step();
      i++;
    end
    check("pub_wait", 32'((pub_q.size() - pbase) >= n), 32'd1);
  endtask

  task automatic wait_idle();
    int i = 0;
    while (cs !== 1'b1 && i < 80 * D) begin
      step();
      i++;
    end
    check("idle_wait", 32'(cs), 32'd1);
    repeat (3) step();
  endtask

  task automatic check_run(input int exp_npub);
    int   npub, nfr, a;
    pub_t p;
    npub = pub_q.size() - pbase;
    check("pub_count", npub, exp_npub);
    a = lowest_ch(run_mask);
    for (int j = 0; j < npub; j++) begin
      p = pub_q[pbase + j];
      exp_bits[a[2:0]] = (val[a[2:0]] > run_thr);
      check("pub_ch", 32'(p.ch), a);
      check("pub_data", 32'(p.data), 32'(val[a[2:0]]));
      check("pub_bits", 32'(p.bits), 32'(exp_bits));
      a = next_ref(run_mask, a);
    end
    nfr = addr_q.size() - abase;
    check("frame_count", nfr, npub + 1);
    a = lowest_ch(run_mask);
    for (int i = 0; i < nfr; i++) begin
      check("din_addr", addr_q[abase + i], a);
      a = next_ref(run_mask, a);
    end
    if (npub > 0) check("first_pub_latency", pub_q[pbase].cyc - cs_fall_cyc, 64 * D + 1);
  endtask

  task automatic finish_run(input int n);
    wait_pubs(n);
    enable = 1'b0;
    wait_idle();
    check_run(n + 1);
  endtask

  initial begin
    int cr, cf, fb, nrun;
    logic [7:0] m;
    for (int i = 0; i < 8; i++) val[i] = '0;

    // Reset state
    repeat (3) step();
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd1);
    check("rst_din", 32'(din), 32'd0);
    check("rst_data", 32'(sample_data), 32'd0);
    check("rst_ch", 32'(sample_ch), 32'd0);
    check("rst_valid", 32'(sample_valid), 32'd0);
    check("rst_bits", 32'(digital_bits), 32'd0);
    rst = 1'b0;
    repeat (3) step();

    // Channel 0 only, no gap between frames
    val[0] = 12'hABC;
    start_run(8'h01, 12'h800);
    cr = cs_rise_cyc;
    wait_pubs(1);
    check("t1_cs_low", 32'(cs), 32'd0);
    check("t1_no_cs_gap", cs_rise_cyc, cr);
    enable = 1'b0;
    wait_idle();
    check_run(2);
    check("t1_bits", 32'(digital_bits), 32'h01);

    // Round-robin with wrap
    for (int i = 0; i < 8; i++) val[i] = 12'(i * 12'h100);
    start_run(8'h85, 12'h250);
    finish_run(3);

    // Threshold edge: strictly greater
    val[0] = 12'h800; val[1] = 12'h801; val[2] = 12'h7FF;
    start_run(8'h07, 12'h800);
    finish_run(3);
    check("t3_edge_bits", 32'(digital_bits[2:0]), 32'b010);

    // Enable drop at the 8th SCLK of frame 3
    val[0] = 12'($urandom_range(0, 4095));
    start_run(8'h01, 12'($urandom_range(0, 4095)));
    begin
      int i = 0;
      while ((n_fall - fbase) < 40 && i < 4 * 32 * D) begin step(); i++; end
    end
    enable = 1'b0;
    wait_idle();
    check("t4_falls", n_fall - fbase, 48);
    check("t4_rises", n_rise - rbase, 48);
    check("t4_cs_after_rise", cs_rise_cyc - last_rise_cyc, 1);
    check("t4_sclk_idle", 32'(sclk), 32'd1);
    check_run(2);
    repeat (4 * D) step();
    check("t4_no_more_rises", n_rise - rbase, 48);

    // Mid-frame reset at the 10th SCLK
    for (int i = 0; i < 8; i++) val[i] = 12'($urandom_range(0, 4095));
    start_run(8'($urandom_range(1, 255)), 12'($urandom_range(0, 4095)));
    begin
      int i = 0;
      while ((n_fall - fbase) < 10 && i < 2 * 32 * D) begin step(); i++; end
    end
    rst = 1'b1;
    #1;
    check("t5_cs", 32'(cs), 32'd1);
    check("t5_sclk", 32'(sclk), 32'd1);
    check("t5_valid", 32'(sample_valid), 32'd0);
    check("t5_bits", 32'(digital_bits), 32'd0);
    check("t5_no_pub", pub_q.size() - pbase, 0);
    exp_bits = '0;
    for (int i = 0; i < 8; i++) val[i] = 12'($urandom_range(0, 4095));
    start_run(8'($urandom_range(1, 255)), 12'($urandom_range(0, 4095)));
    step();
    rst = 1'b0;
    finish_run(2);

    // Empty mask holds the bus idle
    ch_mask = 8'h00;
    enable  = 1'b1;
    cf = cs_fall_cyc;
    fb = n_fall;
    repeat (1000) step();
    check("t6_cs_idle", 32'(cs), 32'd1);
    check("t6_no_cs_fall", cs_fall_cyc, cf);
    check("t6_no_sclk", n_fall, fb);
    val[4] = 12'($urandom_range(0, 4095));
    start_run(8'h10, 12'($urandom_range(0, 4095)));
    finish_run(1);

    // Randomised runs
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 8; i++) val[i] = 12'($urandom_range(0, 4095));
      m = 8'($urandom_range(1, 255));
      start_run(m, 12'($urandom_range(0, 4095)));
      val[lowest_ch(m)] = run_thr;
      nrun = $urandom_range(1, 4);
      finish_run(nrun);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/adc_scan_controller.md
Name: adc_scan_controller

Overview:
- Sequencer for the board's 8-channel, 12-bit serial ADC (ADC128S022-style frame: 16 SCLK, address on DIN, result on DOUT).
- Owns CS/SCLK/DIN, round-robins over the enabled channels and deserialises each result.
- Publishes each result with its channel tag and a per-channel threshold bit for the position-detection logic.
- Replaces the free-running divider/shift-counter read path with a controlled, channel-addressed scan.

Parameters:
CLK_DIV, 25, SCLK half-period in int_clk cycles (50 MHz / 50 = 1 MHz SCLK); legal range >= 4
NUM_CH, 8, number of ADC channels; fixed at 8 because the address is 3 bits
DATA_W, 12, conversion width

Ports:
int_clk  in  1  system clock, 50 MHz
rst  in  1  asynchronous, active-high reset
enable  in  1  scan run request, level-sensitive
ch_mask  in  8  channel enable mask; bit n enables channel n
threshold  in  12  comparison level for digital_bits
dout  in  1  ADC serial data out (asynchronous to int_clk)
cs  out  1  ADC chip select, active low
sclk  out  1  ADC serial clock, idles high
din  out  1  ADC serial data in (address bits)
sample_data  out  12  last result, MSB-first assembled
sample_ch  out  3  channel that sample_data belongs to
sample_valid  out  1  one-cycle strobe, new sample_data/sample_ch
digital_bits  out  8  per-channel (sample > threshold) flags

Behaviour:
- Reset state:
  - cs=1, sclk=1, din=0, sample_data=0, sample_ch=0, sample_valid=0, digital_bits=0.
  - FSM in IDLE; dout synchroniser cleared.
  - Reset is asynchronous. Assertion mid-frame forces these values immediately; the frame is abandoned and produces no sample.
- dout passes a 2-flop synchroniser before sampling.
- States:
  - IDLE: cs=1. Go to START when enable=1 and ch_mask!=0, both sampled in the same cycle.
  - START: cs=0, sclk=1 for CLK_DIV cycles; load addr = lowest set bit of ch_mask. Go to SHIFT.
  - SHIFT: 16 SCLK periods, each = CLK_DIV cycles low then CLK_DIV cycles high.
- Bit timing within a frame:
  - On each SCLK falling edge k (k = 1..16), din = address bit for that position: k=3 ADD2, k=4 ADD1, k=5 ADD0, all other positions 0.
  - At each SCLK rising edge k, capture synced dout into a shift register.
  - Bits k = 5..16 form D11..D0; bits 1..4 are ignored.
- Pipeline: the result read in frame N belongs to the address sent in frame N-1.
  - The controller keeps prev_ch.
  - The first frame of a run has no valid predecessor; its result is discarded (no sample_valid).
- End of frame, on the cycle after the 16th rising edge:
  - If not the run's first frame: sample_data <= assembled word, sample_ch <= prev_ch, sample_valid=1 for exactly one cycle, digital_bits[prev_ch] <= (word > threshold), strictly greater, unsigned 12-bit. Other digital_bits bits are held.
  - Then prev_ch <= addr.
  - Then choose the next state:
    - If enable=1 and ch_mask!=0: next addr = next set bit of ch_mask strictly above addr, wrapping from 7 to 0 (a single-bit mask repeats the same channel). Stay in SHIFT back-to-back; cs remains 0 with no gap.
    - Otherwise: cs=1, return to IDLE. The final frame's result is still published, because it belongs to the previous address.
- ch_mask and threshold are sampled only at frame boundaries and at the IDLE->START transition. Changes mid-frame have no effect on the frame in flight.
- Deasserting enable mid-frame always completes the current frame.
- Re-entry from IDLE restarts the pipeline: the first frame is again discarded.
- Frame length = 32*CLK_DIV int_clk cycles. Publishing is 1 cycle after the 16th rising edge.

Decomposition:
- Package adc_pkg holds:
  - FRAME_BITS=16
  - ADDR_POS_ADD2=3
  - DATA_FIRST_POS=5
  - CH_W=3
  - state enum {IDLE, START, SHIFT}
- Sub-module adc_sclk_gen: CLK_DIV half-period counter producing sclk plus one-cycle fall_pulse/rise_pulse, with synchronous enable and async rst (sclk=1 in reset).
- The controller holds the FSM, bit counter, shift register, channel selection and the output stage.

Test Plan:
1. Channel 0 only, ADC model returning 0xABC: ch_mask=0x01, threshold=0x800, enable=1 -> frame 1 has no sample_valid; frame 2 gives sample_valid with sample_data=0xABC, sample_ch=0, digital_bits=0x01; cs stays low between frames.
2. Round-robin with wrap: ch_mask=0x85, model channel n -> 0x100*n -> din addresses 0,2,7,0,2... and published (ch,data) = (0,0x000),(2,0x200),(7,0x700),(0,0x000).
3. Threshold edge: model value 0x800 with threshold=0x800 -> digital bit 0; value 0x801 -> 1; value 0x7FF -> 0.
4. Enable drop: enable=0 at the 8th SCLK of frame 3 -> frame completes all 16 SCLK, one sample_valid is issued, then cs=1 within 1 cycle, sclk idles high.
5. Mid-frame reset: rst pulse at the 10th SCLK -> cs=1, sclk=1, sample_valid=0, digital_bits=0 immediately with no clock edge; after release with enable=1 the first frame is discarded again.
6. Empty mask: ch_mask=0x00, enable=1 for 1000 cycles -> cs stays 1 and no SCLK toggles; set ch_mask=0x10 -> START begins, addressing channel 4.
